// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//   Brings up the system PLL and releases the downstream clock-domain resets in
//   order. The PLL areset is pulsed first. The design then waits for a lock that
//   holds for LOCK_STABLE_CYCLES consecutive cycles, and releases the domain
//   resets one at a time, STAGE_GAP cycles apart. If the lock does not arrive
//   within LOCK_TIMEOUT cycles, the PLL is reset again. If the lock is lost
//   after release has begun, all domains go back into reset and the design
//   waits for lock again.
//
// Ports
//   iCLK         free-running reference clock (not PLL-derived)
//   iRESETn      asynchronous active-low reset
//   iPLL_LOCKED  PLL lock flag, asynchronous to iCLK
//   iSW_RESTART  single-cycle pulse that restarts the whole sequence
//   oPLL_ARESET  PLL asynchronous reset, active high
//   oRST_n       per-domain active-low resets; bit 0 is released first
//   oREADY       every domain is out of reset and has settled
//   oSTATE       current sequencer state code
//   oRETRY_CNT   count of PLL re-pulses caused by lock timeout (saturating)
//   oLOSS_CNT    count of lock losses after release began (saturating)
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned ARESET_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT       = 1024,
    parameter int unsigned N_STAGES           = 3,
    parameter int unsigned STAGE_GAP          = 32,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    input  logic                iPLL_LOCKED,
    input  logic                iSW_RESTART,
    output logic                oPLL_ARESET,
    output logic [N_STAGES-1:0] oRST_n,
    output logic                oREADY,
    output logic [2:0]          oSTATE,
    output logic [7:0]          oRETRY_CNT,
    output logic [7:0]          oLOSS_CNT
);

    localparam int unsigned STAGE_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int unsigned EVT_W   = 8;

    localparam logic [CNT_W-1:0]   ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST   = STAGE_W'(N_STAGES - 1);
    localparam logic [EVT_W-1:0]   EVT_MAX      = '1;

    typedef enum logic [2:0] {
        PLL_RST     = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_STABLE = 3'd2,
        RELEASE     = 3'd3,
        RUN         = 3'd4
    } state_t;

    state_t              state,      stateNxt;
    logic [CNT_W-1:0]    cnt,        cntNxt;
    logic [STAGE_W-1:0]  stage,      stageNxt;
    logic                pllAreset,  pllAresetNxt;
    logic [N_STAGES-1:0] rstN,       rstNNxt;
    logic                ready,      readyNxt;
    logic [EVT_W-1:0]    retryCnt,   retryCntNxt;
    logic [EVT_W-1:0]    lossCnt,    lossCntNxt;

    logic                lkMeta;
    logic                lk;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            lkMeta <= 1'b0;
            lk     <= 1'b0;
        end else begin
            lkMeta <= iPLL_LOCKED;
            lk     <= lkMeta;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state     <= PLL_RST;
            cnt       <= '0;
            stage     <= '0;
            pllAreset <= 1'b1;
            rstN      <= '0;
            ready     <= 1'b0;
            retryCnt  <= '0;
            lossCnt   <= '0;
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            stage     <= stageNxt;
            pllAreset <= pllAresetNxt;
            rstN      <= rstNNxt;
            ready     <= readyNxt;
            retryCnt  <= retryCntNxt;
            lossCnt   <= lossCntNxt;
        end
    end

    // Next-state and next-output logic; software restart outranks everything.
    always_comb begin
        stateNxt     = state;
        cntNxt       = cnt;
        stageNxt     = stage;
        pllAresetNxt = pllAreset;
        rstNNxt      = rstN;
        readyNxt     = ready;
        retryCntNxt  = retryCnt;
        lossCntNxt   = lossCnt;

        if (iSW_RESTART) begin
            stateNxt     = PLL_RST;
            cntNxt       = '0;
            stageNxt     = '0;
            pllAresetNxt = 1'b1;
            rstNNxt      = '0;
            readyNxt     = 1'b0;
        end else begin
            unique case (state)
                PLL_RST: begin
                    if (cnt == ARESET_LAST) begin
                        cntNxt       = '0;
                        pllAresetNxt = 1'b0;
                        stateNxt     = WAIT_LOCK;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (lk) begin
                        cntNxt   = '0;
                        stateNxt = LOCK_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retryCnt != EVT_MAX) begin
                            retryCntNxt = retryCnt + EVT_W'(1);
                        end
                        cntNxt       = '0;
                        pllAresetNxt = 1'b1;
                        stateNxt     = PLL_RST;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end

                // A drop here is a settling glitch, not a loss event.
                LOCK_STABLE: begin
                    if (!lk) begin
                        cntNxt   = '0;
                        stateNxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        rstNNxt  = N_STAGES'(1);
                        stageNxt = '0;
                        cntNxt   = '0;
                        stateNxt = RELEASE;
                    end else begin
                        cntNxt = cnt + CNT_W'(1);
                    end
                end

                RELEASE, RUN: begin
                    if (!lk) begin
                        // Lock lost once domains may be running: pull every
                        // domain back into reset; the PLL is not re-pulsed.
                        rstNNxt  = '0;
                        readyNxt = 1'b0;
                        stageNxt = '0;
                        cntNxt   = '0;
                        if (lossCnt != EVT_MAX) begin
                            lossCntNxt = lossCnt + EVT_W'(1);
                        end
                        stateNxt = WAIT_LOCK;
                    end else if (state == RELEASE) begin
                        if (cnt == GAP_LAST) begin
                            cntNxt = '0;
                            if (stage == STAGE_LAST) begin
                                readyNxt = 1'b1;
                                stateNxt = RUN;
                            end else begin
                                stageNxt = stage + STAGE_W'(1);
                                // Shift in a one so resets stay thermometer-ordered.
                                rstNNxt  = N_STAGES'({rstN, 1'b1});
                            end
                        end else begin
                            cntNxt = cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    stateNxt     = PLL_RST;
                    cntNxt       = '0;
                    stageNxt     = '0;
                    pllAresetNxt = 1'b1;
                    rstNNxt      = '0;
                    readyNxt     = 1'b0;
                end
            endcase
        end
    end

    assign oPLL_ARESET = pllAreset;
    assign oRST_n      = rstN;
    assign oREADY      = ready;
    assign oSTATE      = 3'(state);
    assign oRETRY_CNT  = retryCnt;
    assign oLOSS_CNT   = lossCnt;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sequences bring-up of the system PLL and the reset release of the clock domains it feeds. Pulses the PLL asynchronous reset, waits for a stable lock, then releases N per-domain active-low resets in a fixed order with programmable spacing. Detects lock loss and lock timeout and recovers automatically. Sits in the top level between the reset/8 MHz input and the PLL plus the downstream domain logic, replacing the ad-hoc free-running reset counter.

Parameters:
ARESET_CYCLES, 16, cycles oPLL_ARESET is held high per PLL reset pulse (>=1)
LOCK_STABLE_CYCLES, 64, consecutive synchronized-lock cycles required before release (>=1)
LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before re-pulsing PLL reset (>=1)
N_STAGES, 3, number of domain reset outputs (1..8)
STAGE_GAP, 32, cycles between successive stage releases, and from last stage to oREADY (>=1)
CNT_W, 16, shared counter width; must hold max(all cycle parameters)

Ports:
iCLK  input  1  free-running 8 MHz reference clock, not PLL-derived
iRESETn  input  1  asynchronous active-low reset
iPLL_LOCKED  input  1  PLL locked flag, asynchronous to iCLK
iSW_RESTART  input  1  single-cycle pulse: full restart of sequence
oPLL_ARESET  output  1  PLL areset, active high
oRST_n  output  N_STAGES  domain resets, active low; bit 0 released first
oREADY  output  1  all domains out of reset and settled
oSTATE  output  3  current state encoding
oRETRY_CNT  output  8  PLL reset re-pulses due to timeout, saturating at 255
oLOSS_CNT  output  8  lock-loss events after release began, saturating at 255

Behaviour:
- Clock and reset: one clock iCLK; reset iRESETn is asynchronous assert, active-low. All outputs registered.
- Reset values: oPLL_ARESET=1, oRST_n=all 0, oREADY=0, oSTATE=PLL_RST, oRETRY_CNT=0, oLOSS_CNT=0, counter=0, stage index=0, synchronizer flops=0.
- iPLL_LOCKED passes through a 2-flop synchronizer -> lk. Input-to-lk latency 2 cycles. All decisions use lk only.
- States and oSTATE codes: PLL_RST=0, WAIT_LOCK=1, LOCK_STABLE=2, RELEASE=3, RUN=4. Codes 5-7 unused and recover to PLL_RST.
- PLL_RST:
  - oPLL_ARESET=1; counter increments each cycle.
  - At counter==ARESET_CYCLES-1: counter<=0, oPLL_ARESET<=0, go WAIT_LOCK.
- WAIT_LOCK:
  - If lk=1: counter<=0, go LOCK_STABLE.
  - Else if counter==LOCK_TIMEOUT-1: oRETRY_CNT++ (saturating), counter<=0, oPLL_ARESET<=1, go PLL_RST.
  - Else counter++.
- LOCK_STABLE:
  - If lk=0: counter<=0, go WAIT_LOCK. Not counted as a loss.
  - At counter==LOCK_STABLE_CYCLES-1 with lk=1: oRST_n[0]<=1, stage<=0, counter<=0, go RELEASE.
- RELEASE:
  - Counter increments each cycle.
  - At counter==STAGE_GAP-1: if stage==N_STAGES-1, oREADY<=1 and go RUN; else stage++, oRST_n[stage+1]<=1, counter<=0.
  - Net effect: resets rise STAGE_GAP cycles apart; oREADY rises STAGE_GAP cycles after the last reset.
- RUN: hold all outputs steady.
- Lock loss (lk=0 in RELEASE or RUN), on that same edge:
  - oRST_n<=all 0, oREADY<=0.
  - oLOSS_CNT++ (saturating), counter<=0.
  - Go WAIT_LOCK; no PLL reset pulse is issued.
- iSW_RESTART=1 in any state has highest priority, including over lock loss on the same cycle:
  - oRST_n<=0, oREADY<=0, oPLL_ARESET<=1, counter<=0, go PLL_RST.
  - Counters oRETRY_CNT and oLOSS_CNT are not changed.
- Reset asserted mid-sequence: everything immediately returns to reset values.
- Released resets never deassert out of order; a bit of oRST_n is never 1 while a lower bit is 0.

Test Plan:
- Default parameters, iPLL_LOCKED=1 from t0, reset released at edge E:
  - oPLL_ARESET high for exactly 16 cycles after E.
  - oRST_n[0] rises 64 cycles after LOCK_STABLE entry.
  - oRST_n[1] and oRST_n[2] rise +32 and +64 cycles after oRST_n[0]; oREADY rises +96.
- iPLL_LOCKED=0 permanently:
  - WAIT_LOCK lasts 1024 cycles, then a 16-cycle oPLL_ARESET pulse; repeats.
  - oRETRY_CNT counts 1, 2, 3 and saturates at 255 after 255 timeouts.
- Lock glitch low for 3 cycles at LOCK_STABLE cycle 40 -> returns to WAIT_LOCK, stable count restarts; oRST_n stays 0 and oLOSS_CNT stays 0.
- In RUN, drop iPLL_LOCKED:
  - oRST_n=000 and oREADY=0 exactly 3 edges after the input falls; oLOSS_CNT=1.
  - Restore lock -> full staged release repeats with no oPLL_ARESET pulse.
- iSW_RESTART pulse during RELEASE with stage=1 (oRST_n=011) -> next cycle oRST_n=000, oPLL_ARESET=1, oSTATE=0; counters unchanged.
- Assert iRESETn=0 asynchronously mid-RELEASE -> outputs go to reset values without waiting for a clock edge; release of iRESETn restarts from PLL_RST.
